go_trigger: RTL and testbench

GO_TRIGGER -- requirements
Module: go_trigger

---
 rtl/go_trigger_pkg.sv | 25 ++
 rtl/go_trigger_bit_sync.sv | 33 +++
 rtl/go_trigger.sv | 128 ++++++++++++
 tb/tb_go_trigger.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/go_trigger_pkg.sv
// go_trigger_pkg: shared FSM state type and default constants for go_trigger.
// Revision: 1.0
`default_nettype none

package go_trigger_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_SYNC_STAGES     = 2;
   localparam int GO_COUNT_W          = 8;

   // Debounced level is high once a press has been accepted, until the release is accepted.
   function automatic logic level_of(input state_e s);
      return (s == ST_PRESSED) || (s == ST_RELEASE_WAIT);
   endfunction

endpackage

`default_nettype wire

// File: rtl/go_trigger_bit_sync.sv
// bit_sync: DEPTH-stage flop chain bringing an asynchronous level into the clk domain.
// Revision: 1.0
`default_nettype none

module bit_sync #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] sync_q;
   logic [DEPTH-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[DEPTH-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/go_trigger.sv
// go_trigger: debounces a push button and issues one go pulse per accepted press.
// Optional go counter enabled by macro GO_TRIGGER_GO_COUNT_EN. Revision: 1.0
`default_nettype none

module go_trigger
   import go_trigger_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  btn_in,
   input  logic                  enable,
   output logic                  go,
   output logic                  btn_level
`ifdef GO_TRIGGER_GO_COUNT_EN
   ,
   output logic [GO_COUNT_W-1:0] go_count
`endif
);

   localparam int             CNT_W  = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] C_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   logic             btn_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             go_q, go_d;
   logic             lvl_q, lvl_d;

   bit_sync #(
      .DEPTH (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (btn_in),
      .q     (btn_s)
   );

   // The terminal count always forces a state exit, so cnt never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      go_d    = 1'b0;
      case (state_q)
         ST_RELEASED: begin
            if (btn_s) begin
               state_d = ST_PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!btn_s) begin
               state_d = ST_RELEASED;
            end else if (cnt_q == C_TERM) begin
               state_d = ST_PRESSED;
               go_d    = enable;
            end else begin
               cnt_d = cnt_q + C_ONE;
            end
         end
         ST_PRESSED: begin
            if (!btn_s) begin
               state_d = ST_RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         ST_RELEASE_WAIT: begin
            // Returning to PRESSED here is a release glitch, not a new press: no go.
            if (btn_s) begin
               state_d = ST_PRESSED;
            end else if (cnt_q == C_TERM) begin
               state_d = ST_RELEASED;
            end else begin
               cnt_d = cnt_q + C_ONE;
            end
         end
         default: begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
         end
      endcase
      lvl_d = level_of(state_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RELEASED;
         cnt_q   <= '0;
         go_q    <= 1'b0;
         lvl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         go_q    <= go_d;
         lvl_q   <= lvl_d;
      end
   end

   assign go        = go_q;
   assign btn_level = lvl_q;

`ifdef GO_TRIGGER_GO_COUNT_EN
   logic [GO_COUNT_W-1:0] go_count_q, go_count_d;

   always_comb begin
      go_count_d = go_count_q;
      if (go_q && (go_count_q != {GO_COUNT_W{1'b1}})) begin
         go_count_d = go_count_q + GO_COUNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         go_count_q <= '0;
      end else begin
         go_count_q <= go_count_d;
      end
   end

   assign go_count = go_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_go_trigger.sv
// tb_go_trigger: vector tables, corner sequences and random stimulus against a debounce model.
// Revision: 1.0
`default_nettype none

module tb_go_trigger;

   localparam int D  = 4;
   localparam int SS = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic btn_in;
   logic enable;
   logic go;
   logic btn_level;
`ifdef GO_TRIGGER_GO_COUNT_EN
   logic [7:0] go_count;
`endif

   go_trigger #(
      .DEBOUNCE_CYCLES (D),
      .SYNC_STAGES     (SS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_in    (btn_in),
      .enable    (enable),
      .go        (go),
      .btn_level (btn_level)
`ifdef GO_TRIGGER_GO_COUNT_EN
      ,
      .go_count  (go_count)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int gos    = 0;

   typedef struct {
      logic btn;
      logic en;
      logic go;
      logic lvl;
   } vec_t;

   // Model: the debounced level flips once the synchronized input has disagreed
   // with it on D+1 consecutive samples; go marks a 0->1 flip taken while enabled.
   logic m_sh [SS];
   logic m_lvl;
   int   m_run;
   logic m_go;
   int   m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < SS; i++) m_sh[i] = 1'b0;
      m_lvl = 1'b0;
      m_run = 0;
      m_go  = 1'b0;
      m_cnt = 0;
   endtask

   task automatic model_step(input logic b, input logic e);
      logic bs;
      bs = m_sh[SS-1];
      for (int i = SS-1; i > 0; i--) m_sh[i] = m_sh[i-1];
      m_sh[0] = b;
      if (m_go && m_cnt < 255) m_cnt++;
      m_go = 1'b0;
      if (bs != m_lvl) begin
         m_run++;
         if (m_run == D + 1) begin
            m_go  = !m_lvl && e;
            m_lvl = !m_lvl;
            m_run = 0;
         end
      end else begin
         m_run = 0;
      end
   endtask

   task automatic cyc(input logic b, input logic e);
      btn_in = b;
      enable = e;
      @(posedge clk);
      model_step(b, e);
      #1;
      chk("go_vs_model", go, m_go);
      chk("level_vs_model", btn_level, m_lvl);
`ifdef GO_TRIGGER_GO_COUNT_EN
      chk("go_count_vs_model", go_count, m_cnt);
`endif
      if (go === 1'b1) gos++;
   endtask

   task automatic run_tbl(input string nm, input vec_t t[$]);
      for (int i = 0; i < t.size(); i++) begin
         cyc(t[i].btn, t[i].en);
         chk({nm, "_go"}, go, t[i].go);
         chk({nm, "_level"}, btn_level, t[i].lvl);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("reset_go", go, 1'b0);
      chk("reset_level", btn_level, 1'b0);
`ifdef GO_TRIGGER_GO_COUNT_EN
      chk("reset_go_count", go_count, 8'd0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t press_tbl[$];
   vec_t glitch_tbl[$];

   initial begin
      int drops;
      logic b;
      logic e;
      int   len;

      // Edge 0 is the first sample of btn_in=1; go follows edge SS+D = 6.
      for (int i = 0; i < 10; i++)
         press_tbl.push_back('{btn: 1'b1, en: 1'b1, go: (i == 6), lvl: (i >= 6)});
      glitch_tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
      glitch_tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
      glitch_tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
      glitch_tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
      for (int i = 0; i < 8; i++) glitch_tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0});

      btn_in = 1'b0;
      enable = 1'b1;
      do_reset();
      idle(3);

      run_tbl("clean_press", press_tbl);
      idle(10);
      chk("level_after_release", btn_level, 1'b0);

      run_tbl("bounce", glitch_tbl);

      gos   = 0;
      drops = 0;
      for (int i = 0; i < 72; i++) begin
         cyc((i == 50 || i == 51) ? 1'b0 : 1'b1, 1'b1);
         if (i >= 6 && btn_level !== 1'b1) drops++;
      end
      chk("hold_glitch_go_total", gos, 1);
      chk("hold_glitch_level_drops", drops, 0);
      idle(10);

      gos = 0;
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
      chk("suppressed_press_go", gos, 0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1);
      chk("no_replay_on_enable", gos, 0);
      idle(10);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1);
      chk("second_press_go", gos, 1);
      idle(10);

      // Reset while the go pulse is high.
      for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1);
      chk("pulse_before_reset", go, 1'b1);
      do_reset();
      run_tbl("press_after_pulse_reset", press_tbl);
      idle(10);

      // Reset in the middle of the press debounce.
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
      do_reset();
      run_tbl("press_after_wait_reset", press_tbl);
      idle(10);

      for (int n = 0; n < 300; n++) begin
         b   = 1'($urandom_range(0, 1));
         e   = ($urandom_range(0, 3) != 0);
         len = $urandom_range(1, 10);
         for (int k = 0; k < len; k++) cyc(b, e);
      end
      idle(10);

`ifdef GO_TRIGGER_GO_COUNT_EN
      for (int p = 0; p < 260; p++) begin
         for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1);
         for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1);
      end
      chk("go_count_saturated", go_count, 8'd255);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
